// File: rtl/mnist_pkg.sv
// Shared types and constants for the MNIST classifier decision stage.
// Imported by the score collector, the requantizer and the argmax block.
package mnist_pkg;

  localparam int unsigned NUM_CLASSES = 10;
  localparam int unsigned SCORE_W     = 8;
  localparam int unsigned DIGIT_W     = 4;

  typedef logic [SCORE_W-1:0] score_t;

  typedef enum logic [0:0] {
    COLLECT,
    DRAIN
  } collect_state_e;

endpackage

// File: rtl/score_requant.sv
// Combinational requantizer: arithmetic right shift of a signed accumulator,
// then clamp into the unsigned 8-bit score range.
module score_requant
  import mnist_pkg::*;
#(
  parameter int unsigned IN_W  = 24,
  parameter int unsigned SHIFT = 8
) (
  input  logic signed [IN_W-1:0] acc,
  output score_t                 score
);

  logic signed [IN_W-1:0] shifted;

  always_comb begin
    shifted = acc >>> SHIFT;
    if (shifted[IN_W-1]) begin
      score = '0;
    end else if (|shifted[IN_W-2:SCORE_W]) begin
      score = '1;
    end else begin
      score = shifted[SCORE_W-1:0];
    end
  end

endmodule

// File: rtl/score_collector.sv
// Collects one requantized score per beat into a class vector, commits it to
// the argmax block, and captures the returned digit after the argmax latency.
module score_collector
  import mnist_pkg::*;
#(
  parameter int unsigned IN_W       = 24,
  parameter int unsigned SHIFT      = 8,
  parameter int unsigned ARGMAX_LAT = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic signed [IN_W-1:0] in_data,
  input  logic                   in_last,
  output score_t                 score [0:NUM_CLASSES-1],
  output logic                   score_valid,
  input  logic [DIGIT_W-1:0]     digit,
  output logic [DIGIT_W-1:0]     result_digit,
  output logic                   result_valid,
  output logic                   frame_err
);

  localparam int unsigned IdxW = $clog2(NUM_CLASSES);
  localparam int unsigned CntW = $clog2(ARGMAX_LAT + 1);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_CLASSES - 1);
  localparam logic [CntW-1:0] CntMax  = CntW'(ARGMAX_LAT);

  collect_state_e    state_q, state_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  score_t            buf_q   [0:NUM_CLASSES-1];
  score_t            score_q [0:NUM_CLASSES-1];
  score_t            score_d [0:NUM_CLASSES-1];
  score_t            beat_score;
  logic              commit, err, capture;
  logic              score_valid_q, result_valid_q, frame_err_q;
  logic [DIGIT_W-1:0] result_q;

  score_requant #(
    .IN_W  (IN_W),
    .SHIFT (SHIFT)
  ) u_requant (
    .acc   (in_data),
    .score (beat_score)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    err     = 1'b0;
    capture = 1'b0;
    case (state_q)
      COLLECT: begin
        if (in_valid) begin
          if (idx_q == LastIdx) begin
            idx_d = '0;
            if (in_last) begin
              commit  = 1'b1;
              cnt_d   = '0;
              state_d = DRAIN;
            end else begin
              err = 1'b1;
            end
          end else if (in_last) begin
            idx_d = '0;
            err   = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        // digit reflects the committed scores once the counter reaches the latency
        if (cnt_q == CntMax) begin
          capture = 1'b1;
          state_d = COLLECT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  // The final beat bypasses the buffer straight into the committed vector.
  always_comb begin
    for (int i = 0; i < NUM_CLASSES; i++) begin
      score_d[i] = commit ? buf_q[i] : score_q[i];
    end
    if (commit) begin
      score_d[LastIdx] = beat_score;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= COLLECT;
      idx_q          <= '0;
      cnt_q          <= '0;
      score_valid_q  <= 1'b0;
      result_valid_q <= 1'b0;
      frame_err_q    <= 1'b0;
      result_q       <= '0;
      for (int i = 0; i < NUM_CLASSES; i++) begin
        buf_q[i]   <= '0;
        score_q[i] <= '0;
      end
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      cnt_q          <= cnt_d;
      score_valid_q  <= commit;
      result_valid_q <= capture;
      frame_err_q    <= err;
      if (capture) begin
        result_q <= digit;
      end
      if (state_q == COLLECT && in_valid) begin
        buf_q[idx_q] <= beat_score;
      end
      for (int i = 0; i < NUM_CLASSES; i++) begin
        score_q[i] <= score_d[i];
      end
    end
  end

  assign in_ready     = (state_q == COLLECT);
  assign score        = score_q;
  assign score_valid  = score_valid_q;
  assign result_digit = result_q;
  assign result_valid = result_valid_q;
  assign frame_err    = frame_err_q;

endmodule

// File: tb/tb_score_collector.sv
// Bench for score_collector: a behavioural argmax pipeline closes the digit
// loop, and a frame-level reference model is compared every cycle.
module tb_score_collector;
  import mnist_pkg::*;

  localparam int unsigned LAT = 4;

  typedef struct {
    logic [23:0] data;
    int          exp;
  } vec_t;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid, in_ready, in_last;
  logic signed [23:0] in_data;
  score_t             score [0:NUM_CLASSES-1];
  logic               score_valid, result_valid, frame_err;
  logic [3:0]         digit, result_digit;
  logic [3:0]         am_pipe [0:LAT-1];

  int n_total = 0;
  int n_bad   = 0;
  int n_xfer  = 0;
  int n_res   = 0;
  int n_nrdy  = 0;

  logic [23:0] frame_buf [0:NUM_CLASSES-1];
  vec_t        tbl [0:19];
  int          tbl_dig [0:1];

  // Reference model state
  int exp_score [NUM_CLASSES];
  bit exp_sv, exp_rv, exp_fe, exp_rdy;
  int exp_res;
  int beats [$];
  int busy;

  score_collector #(
    .IN_W       (24),
    .SHIFT      (8),
    .ARGMAX_LAT (LAT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_last      (in_last),
    .score        (score),
    .score_valid  (score_valid),
    .digit        (digit),
    .result_digit (result_digit),
    .result_valid (result_valid),
    .frame_err    (frame_err)
  );

  always #5 clk = ~clk;

  function automatic int requant_ref(input logic [23:0] d);
    int v;
    v = int'($signed(d));
    if (v < 0) return 0;
    if (v / 256 > 255) return 255;
    return v / 256;
  endfunction

  function automatic int argmax_ref(input int s [NUM_CLASSES]);
    int best = 0;
    for (int i = 1; i < NUM_CLASSES; i++) if (s[i] > s[best]) best = i;
    return best;
  endfunction

  function automatic int dut_argmax();
    int s [NUM_CLASSES];
    for (int i = 0; i < NUM_CLASSES; i++) s[i] = int'(score[i]);
    return argmax_ref(s);
  endfunction

  function automatic logic [23:0] rnd_data();
    case ($urandom_range(0, 3))
      0:       return 24'($urandom);
      1:       return 24'($urandom_range(0, 70000));
      2:       return 24'($urandom_range(0, 3000));
      default: return 24'(-int'($urandom_range(1, 5000)));
    endcase
  endfunction

  // Stand-in for the pipelined argmax block
  always @(posedge clk) begin
    am_pipe[0] <= 4'(dut_argmax());
    for (int i = 1; i < LAT; i++) am_pipe[i] <= am_pipe[i-1];
  end
  assign digit = am_pipe[LAT-1];

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_total++;
    n_bad++;
    $display("FAIL %s: timed out waiting (t=%0t)", name, $time);
  endtask

  function automatic int score_mism_zero();
    int m = 0;
    for (int i = 0; i < NUM_CLASSES; i++) if (score[i] != '0) m++;
    return m;
  endfunction

  task automatic reset_model();
    for (int i = 0; i < NUM_CLASSES; i++) exp_score[i] = 0;
    exp_sv  = 1'b0;
    exp_rv  = 1'b0;
    exp_fe  = 1'b0;
    exp_rdy = 1'b1;
    exp_res = 0;
    busy    = 0;
    beats.delete();
  endtask

  // Frame-level model: a queue of accepted scores, committed or discarded whole
  initial begin
    reset_model();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        reset_model();
      end else begin
        exp_sv = 1'b0;
        exp_rv = 1'b0;
        exp_fe = 1'b0;
        if (busy > 0) begin
          busy--;
          if (busy == 0) begin
            exp_rv  = 1'b1;
            exp_res = argmax_ref(exp_score);
            exp_rdy = 1'b1;
          end
        end else if (in_valid) begin
          beats.push_back(requant_ref(in_data));
          if (beats.size() == NUM_CLASSES && in_last) begin
            for (int i = 0; i < NUM_CLASSES; i++) exp_score[i] = beats[i];
            exp_sv  = 1'b1;
            exp_rdy = 1'b0;
            busy    = LAT + 1;
            beats.delete();
          end else if (in_last || beats.size() == NUM_CLASSES) begin
            exp_fe = 1'b1;
            beats.delete();
          end
        end
      end
    end
  end

  // Per-cycle comparison against the model, plus activity counters
  initial begin
    forever begin
      int m;
      @(negedge clk);
      if (in_valid === 1'b1 && in_ready === 1'b1) n_xfer++;
      if (in_ready !== 1'b1) n_nrdy++;
      if (result_valid === 1'b1) n_res++;
      chk("mon_in_ready", int'(in_ready), int'(exp_rdy));
      chk("mon_score_valid", int'(score_valid), int'(exp_sv));
      chk("mon_result_valid", int'(result_valid), int'(exp_rv));
      chk("mon_frame_err", int'(frame_err), int'(exp_fe));
      chk("mon_result_digit", int'(result_digit), exp_res);
      m = 0;
      for (int i = 0; i < NUM_CLASSES; i++) if (int'(score[i]) != exp_score[i]) m++;
      chk("mon_score_mismatches", m, 0);
    end
  end

  task automatic send_beat(input logic [23:0] d, input logic last);
    bit taken = 1'b0;
    #1;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    for (int c = 0; c < 40 && !taken; c++) begin
      @(negedge clk);
      taken = in_ready;
      @(posedge clk);
    end
    if (!taken) fail_now("beat_accept");
  endtask

  task automatic send_frame(input int n, input int last_at, input int max_gap);
    for (int i = 0; i < n; i++) begin
      if (max_gap > 0) begin
        int g = $urandom_range(0, max_gap);
        if (g > 0) begin
          #1 in_valid = 1'b0;
          repeat (g) @(posedge clk);
        end
      end
      send_beat(frame_buf[i], i == last_at);
    end
  endtask

  task automatic drop();
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_result(input int exp, input string name);
    bit got = 1'b0;
    for (int c = 0; c < 12 && !got; c++) begin
      @(negedge clk);
      got = result_valid;
    end
    if (!got) fail_now(name);
    else chk(name, int'(result_digit), exp);
    @(posedge clk);
  endtask

  initial begin
    int lat, low, expd, x0, r0, nr0, m;
    int s [NUM_CLASSES];
    score_t snap [0:NUM_CLASSES-1];

    tbl[0]  = '{24'hFFFC18, 0};    tbl[1]  = '{24'h7FFFFF, 255};
    tbl[2]  = '{24'd65535, 255};   tbl[3]  = '{24'd300, 1};
    tbl[4]  = '{24'd0, 0};         tbl[5]  = '{24'd0, 0};
    tbl[6]  = '{24'd0, 0};         tbl[7]  = '{24'd0, 0};
    tbl[8]  = '{24'd0, 0};         tbl[9]  = '{24'd0, 0};
    tbl[10] = '{24'd256, 1};       tbl[11] = '{24'd255, 0};
    tbl[12] = '{24'hFFFF00, 0};    tbl[13] = '{24'd65280, 255};
    tbl[14] = '{24'd65536, 255};   tbl[15] = '{24'd1000, 3};
    tbl[16] = '{24'h800000, 0};    tbl[17] = '{24'h7FFF00, 255};
    tbl[18] = '{24'd2560, 10};     tbl[19] = '{24'd511, 1};
    tbl_dig[0] = 1;
    tbl_dig[1] = 3;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_score_valid", int'(score_valid), 0);
    chk("rst_result_valid", int'(result_valid), 0);
    chk("rst_frame_err", int'(frame_err), 0);
    chk("rst_result_digit", int'(result_digit), 0);
    chk("rst_score_nonzero", score_mism_zero(), 0);
    rst = 1'b0;
    @(posedge clk);

    // Ascending scores: latency and backpressure window
    for (int k = 0; k < NUM_CLASSES; k++) frame_buf[k] = 24'(k * 256);
    send_frame(NUM_CLASSES, NUM_CLASSES - 1, 0);
    drop();
    @(negedge clk);
    chk("asc_score_valid", int'(score_valid), 1);
    for (int k = 0; k < NUM_CLASSES; k++) chk($sformatf("asc_score%0d", k), int'(score[k]), k);
    lat = 0;
    low = (in_ready == 1'b0) ? 1 : 0;
    for (int c = 1; c < 12 && lat == 0; c++) begin
      @(negedge clk);
      if (result_valid) lat = c;
      else if (!in_ready) low++;
    end
    chk("asc_result_latency", lat, LAT + 1);
    chk("asc_ready_low_cycles", low, LAT + 1);
    chk("asc_result_digit", int'(result_digit), 9);
    @(posedge clk);

    // Saturation / requant table, two frames
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < NUM_CLASSES; i++) frame_buf[i] = tbl[f*10+i].data;
      send_frame(NUM_CLASSES, NUM_CLASSES - 1, 0);
      drop();
      @(negedge clk);
      chk("sat_score_valid", int'(score_valid), 1);
      for (int i = 0; i < NUM_CLASSES; i++)
        chk($sformatf("sat_f%0d_score%0d", f, i), int'(score[i]), tbl[f*10+i].exp);
      @(posedge clk);
      wait_result(tbl_dig[f], "sat_digit");
    end

    // Early last on the 6th beat, then a good frame
    for (int i = 0; i < NUM_CLASSES; i++) snap[i] = score[i];
    for (int i = 0; i < NUM_CLASSES; i++) frame_buf[i] = 24'(i * 512 + 100);
    send_frame(6, 5, 0);
    drop();
    @(negedge clk);
    chk("early_frame_err", int'(frame_err), 1);
    chk("early_score_valid", int'(score_valid), 0);
    m = 0;
    for (int i = 0; i < NUM_CLASSES; i++) if (score[i] != snap[i]) m++;
    chk("early_score_held", m, 0);
    @(posedge clk);
    for (int i = 0; i < NUM_CLASSES; i++) frame_buf[i] = 24'((9 - i) * 256);
    send_frame(NUM_CLASSES, NUM_CLASSES - 1, 0);
    drop();
    @(negedge clk);
    chk("early_next_score_valid", int'(score_valid), 1);
    chk("early_next_score0", int'(score[0]), 9);
    @(posedge clk);
    wait_result(0, "early_next_digit");

    // Missing last, then the next beat starts a fresh frame
    for (int i = 0; i < NUM_CLASSES; i++) frame_buf[i] = 24'($urandom_range(0, 2000));
    send_frame(NUM_CLASSES, -1, 0);
    drop();
    @(negedge clk);
    chk("miss_frame_err", int'(frame_err), 1);
    chk("miss_score_valid", int'(score_valid), 0);
    @(posedge clk);
    for (int i = 0; i < NUM_CLASSES; i++) frame_buf[i] = (i == 4) ? 24'd5000 : 24'd100;
    send_frame(NUM_CLASSES, NUM_CLASSES - 1, 0);
    drop();
    @(negedge clk);
    chk("miss_next_score_valid", int'(score_valid), 1);
    chk("miss_next_score4", int'(score[4]), 19);
    chk("miss_next_score0", int'(score[0]), 0);
    @(posedge clk);
    wait_result(4, "miss_next_digit");

    // Back-to-back frames with in_valid held high
    x0 = n_xfer; r0 = n_res; nr0 = n_nrdy;
    for (int i = 0; i < NUM_CLASSES; i++) frame_buf[i] = 24'(i * 300);
    send_frame(NUM_CLASSES, NUM_CLASSES - 1, 0);
    for (int i = 0; i < NUM_CLASSES; i++) frame_buf[i] = (i == 7) ? 24'd4000 : 24'd50;
    send_frame(NUM_CLASSES, NUM_CLASSES - 1, 0);
    drop();
    repeat (12) @(posedge clk);
    chk("bp_beats", n_xfer - x0, 20);
    chk("bp_results", n_res - r0, 2);
    chk("bp_ready_low_cycles", n_nrdy - nr0, 2 * (LAT + 1));

    // Reset after 5 beats: outputs clear asynchronously
    for (int i = 0; i < NUM_CLASSES; i++) frame_buf[i] = 24'(i * 1000 + 7);
    send_frame(5, -1, 0);
    drop();
    #2 rst = 1'b1;
    #1;
    chk("rstmid_in_ready", int'(in_ready), 1);
    chk("rstmid_result_digit", int'(result_digit), 0);
    chk("rstmid_score_nonzero", score_mism_zero(), 0);
    chk("rstmid_frame_err", int'(frame_err), 0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    for (int i = 0; i < NUM_CLASSES; i++) begin
      frame_buf[i] = 24'($urandom_range(0, 60000));
      s[i] = requant_ref(frame_buf[i]);
    end
    expd = argmax_ref(s);
    send_frame(NUM_CLASSES, NUM_CLASSES - 1, 1);
    drop();
    wait_result(expd, "rstmid_next_digit");

    // Reset during DRAIN
    for (int i = 0; i < NUM_CLASSES; i++) frame_buf[i] = (i == 2) ? 24'd9000 : 24'd10;
    send_frame(NUM_CLASSES, NUM_CLASSES - 1, 0);
    drop();
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("rstdrain_in_ready", int'(in_ready), 1);
    chk("rstdrain_score_nonzero", score_mism_zero(), 0);
    chk("rstdrain_score_valid", int'(score_valid), 0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    for (int i = 0; i < NUM_CLASSES; i++) begin
      frame_buf[i] = rnd_data();
      s[i] = requant_ref(frame_buf[i]);
    end
    expd = argmax_ref(s);
    send_frame(NUM_CLASSES, NUM_CLASSES - 1, 0);
    drop();
    wait_result(expd, "rstdrain_next_digit");

    // Random frames, some malformed, checked by the per-cycle model
    for (int f = 0; f < 40; f++) begin
      int kind = $urandom_range(0, 9);
      for (int i = 0; i < NUM_CLASSES; i++) frame_buf[i] = rnd_data();
      if (kind == 0) begin
        int n = $urandom_range(1, 9);
        send_frame(n, n - 1, 2);
      end else if (kind == 1) begin
        send_frame(NUM_CLASSES, -1, 2);
      end else begin
        send_frame(NUM_CLASSES, NUM_CLASSES - 1, 2);
      end
      drop();
      repeat ($urandom_range(1, 3)) @(posedge clk);
    end

    repeat (10) @(posedge clk);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/score_collector.md
# score_collector

Front end of the classifier decision stage. It accepts the output-layer class accumulators as a serial valid/ready stream, one class per beat, and requantizes each to an 8-bit unsigned score. It assembles the 10-entry `score[0:9]` vector, presents it to the pipelined argmax block, then tracks that block's fixed latency to capture the returned `digit` as a qualified `result_digit`. One frame is in flight at a time.

## Interface
- `NUM_CLASSES`, 10, beats per frame and score vector length.
- `IN_W`, 24, signed accumulator width.
- `SHIFT`, 8, arithmetic right shift applied before clamping.
- `ARGMAX_LAT`, 4, clock edges from a `score` update to a valid `digit`.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: beat valid.
- `in_ready` out 1: collector can accept a beat.
- `in_data` in IN_W: signed accumulator for the current class index.
- `in_last` in 1: marks the final beat of a frame.
- `score` out 8 x NUM_CLASSES: unpacked array `[0:NUM_CLASSES-1]`, driven to the argmax block.
- `score_valid` out 1: single-cycle pulse, `score` newly committed.
- `digit` in 4: argmax result.
- `result_digit` out 4: captured class index.
- `result_valid` out 1: single-cycle pulse, `result_digit` updated.
- `frame_err` out 1: single-cycle pulse, malformed frame discarded.

## Operation
- **Beat transfer:** a beat transfers on a rising edge where `in_valid && in_ready`.
- **States:**
  - `COLLECT`: `in_ready`=1. Each beat writes requant(`in_data`) into `buf[idx]`, then `idx++`.
  - `DRAIN`: `in_ready`=0. A latency counter runs until the result is captured.
- **Requantization:** `q = in_data >>> SHIFT`, computed in IN_W signed arithmetic. Clamp: `q<0` gives 0; `q>255` gives 255; otherwise `q[7:0]`.
- **Good frame:** beat with `idx==NUM_CLASSES-1 && in_last`.
  - Copy `buf` (including this beat) into `score`.
  - Pulse `score_valid`.
  - Set `idx`=0, go to `DRAIN`.
- **Error, early last:** `in_last` with `idx<NUM_CLASSES-1`.
  - Pulse `frame_err`, set `idx`=0, stay in `COLLECT`.
  - `score` is unchanged and `score_valid` is not pulsed.
- **Error, missing last:** beat with `idx==NUM_CLASSES-1 && !in_last`. Handled the same as early last.
- **DRAIN:** counter loads 0 on commit and increments every cycle. When it reaches `ARGMAX_LAT`:
  - Register `digit` into `result_digit` and pulse `result_valid`.
  - Return to `COLLECT`.
- **Output holding:** `score` holds its value between commits, so the argmax input is always stable. `result_digit` holds until the next capture.
- **Reset values (asynchronous, any state):**
  - `score` all 0, `result_digit` 0.
  - `score_valid`, `result_valid`, `frame_err` all 0.
  - `in_ready` 1, state `COLLECT`, `idx` 0.
  - A partial frame in progress is discarded.

## Timing
- Let edge N be the commit edge.
  - `score` and `score_valid` are visible after edge N.
  - The argmax block produces `digit` after edge N+ARGMAX_LAT.
  - `result_digit` and `result_valid` are visible after edge N+ARGMAX_LAT+1, which is N+5 at the defaults.
- `in_ready` is low after edge N and high again after edge N+ARGMAX_LAT+1. That is ARGMAX_LAT+1 cycles of backpressure.
- Minimum frame period is NUM_CLASSES+ARGMAX_LAT+1 cycles (15 at the defaults).
- All outputs are registered, with no combinational path from input to output. `in_ready` does not depend on `in_valid`.
- `frame_err` is visible after the offending edge. The next beat is accepted on the following cycle as `idx` 0.
- `score_valid` and `result_valid` never assert in the same cycle.

## Structure
- **Shared package `mnist_pkg`:**
  - Constants `NUM_CLASSES`, `SCORE_W`=8, `DIGIT_W`=4.
  - `typedef logic [SCORE_W-1:0] score_t`.
  - State enum `collect_state_e {COLLECT, DRAIN}`.
  - The argmax block imports the same `NUM_CLASSES` and `score_t`.
- **Sub-module `score_requant`:** combinational shift and clamp, parameterized by `IN_W` and `SHIFT`. It is reused by the hidden-layer output paths.
- **Top-level verification:** instantiate `score_collector` together with the existing argmax block so the `digit` loop is closed.

## Test plan
- **Ascending scores:** frame `in_data = k*256`, k=0..9, `in_last` on k=9.
  - `score` = 0..9 and `score_valid` after the last edge.
  - `result_digit`=9 and `result_valid` exactly 5 cycles later.
- **Saturation:** beats `-1000`, `0x7FFFFF`, `65535`, `300`, remaining beats 0.
  - `score[0..3]` = 0, 255, 255, 1.
  - Result digit is 1, because ties go to the lower index.
- **Early last:** `in_last` on the 6th beat.
  - `frame_err` pulse, no `score_valid`, `score` unchanged.
  - A following correct frame commits normally.
- **Missing last:** 10th beat without `in_last` gives a `frame_err` pulse. The 11th beat is taken as `idx` 0 of the next frame.
- **Backpressure:** `in_valid` held high across two back-to-back frames.
  - `in_ready` low for 5 cycles after each commit.
  - Exactly 20 beats transfer and two `result_valid` pulses occur, with no lost or duplicated beat.
- **Reset mid-frame:** assert `rst` after 5 beats, then once during `DRAIN`.
  - All outputs return to reset values immediately.
  - The next full frame produces the correct result.
